// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for the serial adder
//
// Purpose: FSM state type and elaboration-time helpers used by serial_adder.
// Ports:   none (package)

package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of clocked steps needed to cover the full operand width.
   function automatic int steps_of(input int width, input int digit);
      return width / digit;
   endfunction

   // One extra bit beyond the index range so the counter can never wrap.
   function automatic int cnt_width(input int steps);
      return $clog2(steps) + 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - single-bit full adder cell
//
// Purpose: one-bit full adder, chained by serial_adder to form a DIGIT-bit ripple chain.
// Ports:   a, b, cin  - addend bits and carry in
//          sum, cout  - sum bit and carry out

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder with valid/ready handshake
//
// Purpose: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock,
//          over WIDTH/DIGIT steps, and reports carry-out and signed overflow.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          in_valid, in_ready       - operand handshake (a, b, cin)
//          a, b, cin                - operands and carry into bit 0
//          out_valid, out_ready     - result handshake (sum, cout, overflow)
//          sum, cout, overflow      - result, carry out of MSB, signed overflow

module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: illegal WIDTH/DIGIT combination");
   end

   localparam int STEPS = steps_of(WIDTH, DIGIT);
   localparam int CW    = cnt_width(STEPS);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;

   logic [DIGIT:0]   c;
   logic [DIGIT-1:0] dsum;
   logic [WIDTH-1:0] res_next;

   // Ripple chain over the current low digit of the operand shift registers.
   assign c[0] = carry;

   for (genvar i = 0; i < DIGIT; i++) begin : g_chain
      full_adder u_fa (
         .a    (a_sh[i]),
         .b    (b_sh[i]),
         .cin  (c[i]),
         .sum  (dsum[i]),
         .cout (c[i+1])
      );
   end

   // New digit enters at the top; after STEPS shifts the first digit sits at bit 0.
   assign res_next = (WIDTH'(dsum) << (WIDTH - DIGIT)) | (res_sh >> DIGIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         res_sh    <= '0;
         carry     <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  carry    <= cin;
                  cnt      <= '0;
                  res_sh   <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               carry  <= c[DIGIT];
               res_sh <= res_next;
               if (cnt == CW'(STEPS - 1)) begin
                  sum       <= res_next;
                  cout      <= c[DIGIT];
                  // c[DIGIT-1] is the carry into the MSB on the last step.
                  overflow  <= c[DIGIT] ^ c[DIGIT-1];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
